display_timings_480p: RTL

DISPLAY_TIMINGS_480P -- requirements
Module: display_timings_480p

---
 rtl/display_timings_480p.sv | 104 ++++++++++
 1 files changed

// File: rtl/display_timings_480p.sv
// display_timings_480p: 640x480 @ 60 Hz style raster timing generator.
// Produces registered screen position, syncs, data enable and line/frame
// pulses, all describing the same pixel in the same cycle.
// Optional feature: define DISPLAY_TIMINGS_FRAME_COUNT_EN to add a 16-bit
// frame counter output (frame_cnt).
module display_timings_480p #(
   parameter int   CORDW    = 10,
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic SYNC_POL = 1'b0
) (
   input  logic             clk_pix,
   input  logic             rst_n,
   input  logic             clk_pix_locked,
   output logic [CORDW-1:0] sx,
   output logic [CORDW-1:0] sy,
   output logic             hsync,
   output logic             vsync,
   output logic             de,
   output logic             frame,
   output logic             line
`ifdef DISPLAY_TIMINGS_FRAME_COUNT_EN
   ,
   output logic [15:0]      frame_cnt
`endif
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CORDW-1:0] H_LAST = CORDW'(H_TOTAL - 1);
   localparam logic [CORDW-1:0] V_LAST = CORDW'(V_TOTAL - 1);
   localparam logic [CORDW-1:0] H_ACT  = CORDW'(H_ACTIVE);
   localparam logic [CORDW-1:0] V_ACT  = CORDW'(V_ACTIVE);
   localparam logic [CORDW-1:0] HS_STA = CORDW'(H_ACTIVE + H_FP);
   localparam logic [CORDW-1:0] HS_END = CORDW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CORDW-1:0] VS_STA = CORDW'(V_ACTIVE + V_FP);
   localparam logic [CORDW-1:0] VS_END = CORDW'(V_ACTIVE + V_FP + V_SYNC);

   // Raster counter. Parked at the last pixel of the frame while held in
   // reset so the first advance lands on (0,0).
   logic [CORDW-1:0] x, y;
   logic [CORDW-1:0] nx, ny;
   logic             n_hs, n_vs, n_de, n_frame, n_line;

   // Next raster position and the decode of that position; decoding the
   // upcoming pixel lets every output be a plain register yet stay aligned.
   always_comb begin
      nx = x + 1'b1;
      ny = y;
      if (x == H_LAST) begin
         nx = '0;
         ny = (y == V_LAST) ? '0 : y + 1'b1;
      end
      n_hs    = (nx >= HS_STA && nx < HS_END) ? SYNC_POL : ~SYNC_POL;
      n_vs    = (ny >= VS_STA && ny < VS_END) ? SYNC_POL : ~SYNC_POL;
      n_de    = (nx < H_ACT) && (ny < V_ACT);
      n_line  = (nx == '0);
      n_frame = (nx == '0) && (ny == '0);
   end

   // Counter and output registers; reset or lock loss drops the frame at once.
   always_ff @(posedge clk_pix) begin
      if (!rst_n || !clk_pix_locked) begin
         x     <= H_LAST;
         y     <= V_LAST;
         sx    <= '0;
         sy    <= '0;
         hsync <= ~SYNC_POL;
         vsync <= ~SYNC_POL;
         de    <= 1'b0;
         frame <= 1'b0;
         line  <= 1'b0;
      end else begin
         x     <= nx;
         y     <= ny;
         sx    <= nx;
         sy    <= ny;
         hsync <= n_hs;
         vsync <= n_vs;
         de    <= n_de;
         frame <= n_frame;
         line  <= n_line;
      end
   end

`ifdef DISPLAY_TIMINGS_FRAME_COUNT_EN
   // Frame counter steps together with the frame pulse, so the first frame
   // after reset already reads 1.
   always_ff @(posedge clk_pix) begin
      if (!rst_n || !clk_pix_locked)
         frame_cnt <= '0;
      else if (n_frame)
         frame_cnt <= frame_cnt + 1'b1;
   end
`endif

endmodule
